// File: rtl/rob_pkg.sv
// Shared types and widths for the reorder buffer: entry record, field widths and pointer helper.
package rob_pkg;
  localparam int SIZE_W     = 32;
  localparam int REG_NUM    = 64;
  localparam int ROB_ROWS_P = 16;
  localparam int PC_W       = 10;
  localparam int MEM_ROWS   = 64;
  localparam int RB_W       = $clog2(REG_NUM);
  localparam int RN_W       = $clog2(ROB_ROWS_P);
  localparam int MA_W       = $clog2(MEM_ROWS);
  localparam int CNT_W      = $clog2(ROB_ROWS_P + 1);

  typedef struct packed {
    logic            valid;
    logic            done;
    logic            is_sw;
    logic [RB_W-1:0] dest_reg;
    logic [RB_W-1:0] old_dest_reg;
    logic [PC_W-1:0] pc;
    logic [SIZE_W-1:0] data;
    logic [MA_W-1:0] addr;
  } rob_entry_t;

  // ROB_ROWS is a power of two, so truncation gives the ring wrap for free.
  function automatic logic [RN_W-1:0] ptr_inc(input logic [RN_W-1:0] ptr, input int n);
    return ptr + RN_W'(n);
  endfunction
endpackage

// File: rtl/rob_commit_sel.sv
// Prefix scan over the oldest COMMIT_W entries: retire in order, stop at the first
// not-ready entry, and let at most one store through per cycle.
module rob_commit_sel
  import rob_pkg::*;
#(
  parameter int COMMIT_W = 2
) (
  input  logic [COMMIT_W-1:0] ent_valid,
  input  logic [COMMIT_W-1:0] ent_done,
  input  logic [COMMIT_W-1:0] ent_sw,
  input  logic [CNT_W-1:0]    count,
  input  logic                flush,
  output logic [COMMIT_W-1:0] commit_valid,
  output logic [COMMIT_W-1:0] store_slot
);
  logic chain;

  always_comb begin
    commit_valid = '0;
    store_slot   = '0;
    chain        = !flush;
    for (int i = 0; i < COMMIT_W; i++) begin
      chain           = chain && ent_valid[i] && ent_done[i] && (CNT_W'(i) < count);
      commit_valid[i] = chain;
      store_slot[i]   = chain && ent_sw[i];
      // A store ends the group so a second store waits for the next cycle.
      chain           = chain && !ent_sw[i];
    end
  end
endmodule

// File: rtl/rob_ring.sv
// Circular reorder buffer: multi-wide in-order dispatch, out-of-order writeback, in-order commit.
// Optional forwarding lookup ports are enabled with `define ROB_FORWARD_EN.
module rob_ring
  import rob_pkg::*;
#(
`ifdef ROB_FORWARD_EN
  parameter int READ_PORTS = 6,
`endif
  parameter int DISPATCH_W = 2,
  parameter int WB_PORTS   = 3,
  parameter int COMMIT_W   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [DISPATCH_W-1:0]        add_valid,
  input  logic [DISPATCH_W*RB_W-1:0]   add_dest_reg,
  input  logic [DISPATCH_W*RB_W-1:0]   add_old_dest_reg,
  input  logic [DISPATCH_W-1:0]        add_is_sw,
  input  logic [DISPATCH_W*PC_W-1:0]   add_pc,
  output logic                         add_ready,
  output logic [DISPATCH_W*RN_W-1:0]   added_robn,
  input  logic [WB_PORTS-1:0]          wb_valid,
  input  logic [WB_PORTS*RN_W-1:0]     wb_robn,
  input  logic [WB_PORTS*SIZE_W-1:0]   wb_data,
  input  logic [WB_PORTS*MA_W-1:0]     wb_addr,
  output logic [COMMIT_W-1:0]          commit_valid,
  output logic [COMMIT_W*RB_W-1:0]     commit_dest_reg,
  output logic [COMMIT_W*RB_W-1:0]     commit_old_dest_reg,
  output logic [COMMIT_W*SIZE_W-1:0]   commit_data,
  output logic [COMMIT_W*PC_W-1:0]     commit_pc,
  output logic                         EnWrite,
  output logic [MA_W-1:0]              write_addr,
  output logic [SIZE_W-1:0]            write_data_mem,
`ifdef ROB_FORWARD_EN
  input  logic [READ_PORTS*RN_W-1:0]   fwd_robn,
  output logic [READ_PORTS-1:0]        fwd_ready,
  output logic [READ_PORTS*SIZE_W-1:0] fwd_data,
`endif
  output logic [CNT_W-1:0]             count
);
  rob_entry_t rob_q [ROB_ROWS_P];
  rob_entry_t rob_d [ROB_ROWS_P];
  logic [RN_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] n_req, n_commit;
  logic [COMMIT_W-1:0] slot_valid, slot_done, slot_sw, store_slot;
  rob_entry_t head_ent [COMMIT_W];

  assign count = count_q;

  generate
    for (genvar gi = 0; gi < COMMIT_W; gi++) begin : g_head
      assign head_ent[gi]   = rob_q[ptr_inc(head_q, gi)];
      assign slot_valid[gi] = head_ent[gi].valid;
      assign slot_done[gi]  = head_ent[gi].done;
      assign slot_sw[gi]    = head_ent[gi].is_sw;
      assign commit_dest_reg[gi*RB_W +: RB_W]     = commit_valid[gi] ? head_ent[gi].dest_reg : '0;
      assign commit_old_dest_reg[gi*RB_W +: RB_W] = commit_valid[gi] ? head_ent[gi].old_dest_reg : '0;
      assign commit_data[gi*SIZE_W +: SIZE_W]     = commit_valid[gi] ? head_ent[gi].data : '0;
      assign commit_pc[gi*PC_W +: PC_W]           = commit_valid[gi] ? head_ent[gi].pc : '0;
    end
  endgenerate

  rob_commit_sel #(.COMMIT_W(COMMIT_W)) u_commit_sel (
    .ent_valid    (slot_valid),
    .ent_done     (slot_done),
    .ent_sw       (slot_sw),
    .count        (count_q),
    .flush        (flush),
    .commit_valid (commit_valid),
    .store_slot   (store_slot)
  );

  always_comb begin
    EnWrite        = |store_slot;
    write_addr     = '0;
    write_data_mem = '0;
    n_commit       = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      n_commit = n_commit + CNT_W'(commit_valid[i]);
      if (store_slot[i]) begin
        write_addr     = head_ent[i].addr;
        write_data_mem = head_ent[i].data;
      end
    end
  end

  // Set request bits take consecutive slots from tail; same-cycle commits are not credited.
  always_comb begin
    n_req      = '0;
    added_robn = '0;
    for (int i = 0; i < DISPATCH_W; i++) begin
      added_robn[i*RN_W +: RN_W] = ptr_inc(tail_q, int'(n_req));
      n_req = n_req + CNT_W'(add_valid[i]);
    end
    add_ready = !flush && ((CNT_W'(ROB_ROWS_P) - count_q) >= n_req);
  end

  always_comb begin
    rob_d = rob_q;
    for (int w = 0; w < WB_PORTS; w++) begin
      if (wb_valid[w] && rob_q[wb_robn[w*RN_W +: RN_W]].valid) begin
        rob_d[wb_robn[w*RN_W +: RN_W]].done = 1'b1;
        rob_d[wb_robn[w*RN_W +: RN_W]].data = wb_data[w*SIZE_W +: SIZE_W];
        rob_d[wb_robn[w*RN_W +: RN_W]].addr = wb_addr[w*MA_W +: MA_W];
      end
    end
    for (int c = 0; c < COMMIT_W; c++) begin
      if (commit_valid[c]) begin
        rob_d[ptr_inc(head_q, c)].valid = 1'b0;
        rob_d[ptr_inc(head_q, c)].done  = 1'b0;
      end
    end
    if (add_ready) begin
      for (int i = 0; i < DISPATCH_W; i++) begin
        if (add_valid[i]) begin
          rob_d[added_robn[i*RN_W +: RN_W]].valid        = 1'b1;
          rob_d[added_robn[i*RN_W +: RN_W]].done         = 1'b0;
          rob_d[added_robn[i*RN_W +: RN_W]].is_sw        = add_is_sw[i];
          rob_d[added_robn[i*RN_W +: RN_W]].dest_reg     = add_dest_reg[i*RB_W +: RB_W];
          rob_d[added_robn[i*RN_W +: RN_W]].old_dest_reg = add_old_dest_reg[i*RB_W +: RB_W];
          rob_d[added_robn[i*RN_W +: RN_W]].pc           = add_pc[i*PC_W +: PC_W];
          rob_d[added_robn[i*RN_W +: RN_W]].data         = '0;
          rob_d[added_robn[i*RN_W +: RN_W]].addr         = '0;
        end
      end
    end
    head_d  = ptr_inc(head_q, int'(n_commit));
    tail_d  = add_ready ? ptr_inc(tail_q, int'(n_req)) : tail_q;
    count_d = count_q + (add_ready ? n_req : '0) - n_commit;
    if (flush) begin
      for (int e = 0; e < ROB_ROWS_P; e++) begin
        rob_d[e].valid = 1'b0;
        rob_d[e].done  = 1'b0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int e = 0; e < ROB_ROWS_P; e++) rob_q[e] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rob_q   <= rob_d;
    end
  end

`ifdef ROB_FORWARD_EN
  generate
    for (genvar gi = 0; gi < READ_PORTS; gi++) begin : g_fwd
      rob_entry_t fwd_ent;
      assign fwd_ent                        = rob_q[fwd_robn[gi*RN_W +: RN_W]];
      assign fwd_ready[gi]                  = fwd_ent.valid && fwd_ent.done;
      assign fwd_data[gi*SIZE_W +: SIZE_W]  = fwd_ent.data;
    end
  endgenerate
`endif
endmodule
